// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access widths, FSM state codes
// and the load extension helper.
package dmem_responder_pkg;

    localparam logic [1:0] MEM_W_BYTE = 2'b00;
    localparam logic [1:0] MEM_W_HALF = 2'b01;
    localparam logic [1:0] MEM_W_WORD = 2'b10;
    localparam logic [1:0] MEM_W_ILL  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int LANES = 4;

    // Extends a selected byte (v[7:0]) or half (v[15:0]) to 32 bits.
    function automatic logic [31:0] ext_lane(input logic [15:0] v,
                                             input logic        is_half,
                                             input logic        sgn);
        logic [31:0] r;
        if (is_half)
            r = sgn ? {{16{v[15]}}, v} : {16'b0, v};
        else
            r = sgn ? {{24{v[7]}}, v[7:0]} : {24'b0, v[7:0]};
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_lane_fmt.sv
// Combinational byte-lane formatter: store enables/data placement, load lane
// extraction with extension, and alignment checking.
module dmem_lane_fmt
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  i_width,
    input  logic        i_sign,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_rd_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rd_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rd_word[31:16] : i_rd_word[15:0];

    always_comb begin
        o_be       = 4'b0000;
        o_wdata    = 32'b0;
        o_ldata    = 32'b0;
        o_misalign = 1'b0;
        case (i_width)
            MEM_W_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_st_data[7:0]}};
                o_ldata = ext_lane({8'b0, w_byte}, 1'b0, i_sign);
            end
            MEM_W_HALF: begin
                o_misalign = i_addr_lo[0];
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_st_data[15:0]}};
                o_ldata    = ext_lane(w_half, 1'b1, i_sign);
            end
            MEM_W_WORD: begin
                o_misalign = (i_addr_lo != 2'b00);
                o_be       = 4'b1111;
                o_wdata    = i_st_data;
                o_ldata    = i_rd_word;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised array with programmable wait states,
// driving the core's stall request and returning formatted load data.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Mem_DcacheEN,
    input  logic                  Mem_DcacheRd,
    input  logic [1:0]            Mem_DcacheWidth,
    input  logic                  Mem_DcacheSign,
    input  logic [ADDR_WIDTH-1:0] Mem_DcacheAddr,
    input  logic [DATA_WIDTH-1:0] EXMem_Rs2Data,
    input  logic                  Csr_Memflush,
    output logic [DATA_WIDTH-1:0] Dcache_DataRd,
    output logic                  Dcache_StallReq,
    output logic                  Dcache_Err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_err;

    logic                  r_rd;
    logic [1:0]            r_width;
    logic                  r_sign;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_st_data;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    logic [ADDR_WIDTH-1:0] w_off;
    logic [ADDR_WIDTH-1:0] w_word;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_oor;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_ldata;
    logic                  w_misalign;
    logic                  w_fault;
    logic                  w_access;
    logic [DATA_WIDTH-1:0] w_rd_word;

    // Unsigned offset: addresses below BASE_ADDR wrap high and fault as out-of-range.
    assign w_off   = r_addr - BASE_ADDR;
    assign w_word  = w_off >> 2;
    assign w_idx   = w_word[IDX_W-1:0];
    assign w_oor   = (w_word >= ADDR_WIDTH'(DEPTH_WORDS));
    assign w_fault = w_oor || w_misalign || (r_width == MEM_W_ILL);

    assign w_access  = (r_state == ST_BUSY) && (r_cnt == 4'd0) && !Csr_Memflush && !rst;
    assign w_rd_word = r_mem[w_idx];

    dmem_lane_fmt u_lane_fmt (
        .i_width    (r_width),
        .i_sign     (r_sign),
        .i_addr_lo  (r_addr[1:0]),
        .i_st_data  (r_st_data),
        .i_rd_word  (w_rd_word),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_ldata    (w_ldata),
        .o_misalign (w_misalign)
    );

    assign Dcache_StallReq = !rst && !Csr_Memflush &&
                             (((r_state == ST_IDLE) && Mem_DcacheEN) || (r_state == ST_BUSY));
    assign Dcache_DataRd   = r_data;
    assign Dcache_Err      = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_data <= '0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Mem_DcacheEN && !Csr_Memflush) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= 4'(WAIT_CYCLES);
                    end
                end
                ST_BUSY: begin
                    if (Csr_Memflush) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= ST_RESP;
                        r_err   <= w_fault;
                        r_data  <= (r_rd && !w_fault) ? w_ldata : '0;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == ST_IDLE) && Mem_DcacheEN) begin
            r_rd      <= Mem_DcacheRd;
            r_width   <= Mem_DcacheWidth;
            r_sign    <= Mem_DcacheSign;
            r_addr    <= Mem_DcacheAddr;
            r_st_data <= EXMem_Rs2Data;
        end
    end

    // Per-lane write enables; faulting or flushed stores never touch the array.
    always_ff @(posedge clk) begin
        if (w_access && !r_rd && !w_fault) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_be[i])
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        en    [2];
    logic        rdq   [2];
    logic [1:0]  wid   [2];
    logic        sgn   [2];
    logic [31:0] addr  [2];
    logic [31:0] wd    [2];
    logic        fl    [2];
    logic [31:0] dout  [2];
    logic        stall [2];
    logic        err   [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(4096),
                     .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst[0]), .Mem_DcacheEN(en[0]), .Mem_DcacheRd(rdq[0]),
        .Mem_DcacheWidth(wid[0]), .Mem_DcacheSign(sgn[0]), .Mem_DcacheAddr(addr[0]),
        .EXMem_Rs2Data(wd[0]), .Csr_Memflush(fl[0]), .Dcache_DataRd(dout[0]),
        .Dcache_StallReq(stall[0]), .Dcache_Err(err[0])
    );

    dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(4096),
                     .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst[1]), .Mem_DcacheEN(en[1]), .Mem_DcacheRd(rdq[1]),
        .Mem_DcacheWidth(wid[1]), .Mem_DcacheSign(sgn[1]), .Mem_DcacheAddr(addr[1]),
        .EXMem_Rs2Data(wd[1]), .Csr_Memflush(fl[1]), .Dcache_DataRd(dout[1]),
        .Dcache_StallReq(stall[1]), .Dcache_Err(err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request and counts stall cycles until the response cycle.
    task automatic access(input int d, input logic r, input logic [1:0] w, input logic s,
                          input logic [31:0] a, input logic [31:0] data,
                          input int exp_stall, input logic [31:0] exp_d,
                          input logic exp_e, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        en[d] = 1'b1; rdq[d] = r; wid[d] = w; sgn[d] = s;
        addr[d] = a; wd[d] = data; fl[d] = 1'b0;
        #1;
        while (stall[d] && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk({tag, ".stall"}, n, exp_stall);
        chk({tag, ".data"}, dout[d], exp_d);
        chk({tag, ".err"}, {31'b0, err[d]}, {31'b0, exp_e});
    endtask

    task automatic idle(input int d, input string tag);
        @(negedge clk);
        en[d] = 1'b0; fl[d] = 1'b0;
        #1;
        chk({tag, ".data0"}, dout[d], 32'h0);
        chk({tag, ".err0"}, {31'b0, err[d]}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; en[i] = 1'b0; rdq[i] = 1'b0; wid[i] = 2'b10;
            sgn[i] = 1'b0; addr[i] = 32'h0; wd[i] = 32'h0; fl[i] = 1'b0;
        end
        en[0] = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {31'b0, stall[0]}, 32'h0);
        chk("rst_data", dout[0], 32'h0);
        chk("rst_err", {31'b0, err[0]}, 32'h0);
        chk("rst_data1", dout[1], 32'h0);
        @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0; en[0] = 1'b0;
        #1;
        chk("idle_stall", {31'b0, stall[0]}, 32'h0);

        // T1
        access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 4, 32'h0, 1'b0, "t1_sw");
        access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 4, 32'hDEADBEEF, 1'b0, "t1_lw");
        idle(0, "t1_after");
        // T2
        access(0, 1'b0, 2'b00, 1'b0, 32'h11, 32'hAAAAAA80, 4, 32'h0, 1'b0, "t2_sb");
        access(0, 1'b1, 2'b00, 1'b1, 32'h11, 32'h0, 4, 32'hFFFFFF80, 1'b0, "t2_lb");
        access(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0, 4, 32'h00000080, 1'b0, "t2_lbu");
        access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 4, 32'hDEAD80EF, 1'b0, "t2_lw");
        // T3
        access(0, 1'b1, 2'b01, 1'b1, 32'h12, 32'h0, 4, 32'hFFFFDEAD, 1'b0, "t3_lh");
        access(0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0, 4, 32'h0000DEAD, 1'b0, "t3_lhu");
        access(0, 1'b1, 2'b00, 1'b1, 32'h13, 32'h0, 4, 32'hFFFFFFDE, 1'b0, "t3_lb3");
        access(0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h0, 4, 32'h000000EF, 1'b0, "t3_lbu0");
        // T4
        access(0, 1'b0, 2'b01, 1'b0, 32'h13, 32'h5555, 4, 32'h0, 1'b1, "t4_sh_mis");
        idle(0, "t4_pulse");
        access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 4, 32'hDEAD80EF, 1'b0, "t4_lw_unch");
        access(0, 1'b1, 2'b10, 1'b0, 32'h4000, 32'h0, 4, 32'h0, 1'b1, "t4_lw_oor");
        access(0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 4, 32'h0, 1'b1, "t4_ill_w");
        access(0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h0, 4, 32'h0, 1'b1, "t4_lw_mis");
        access(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, 4, 32'h0, 1'b0, "t4_sh_hi");
        access(0, 1'b1, 2'b10, 1'b1, 32'h10, 32'h0, 4, 32'h123480EF, 1'b0, "t4_lw_sgn");
        // T5: flush in the second BUSY cycle
        access(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 4, 32'h0, 1'b0, "t5_sw_pre");
        @(negedge clk);
        en[0] = 1'b1; rdq[0] = 1'b0; wid[0] = 2'b10; addr[0] = 32'h20; wd[0] = 32'h12345678;
        #1;
        chk("t5_accept", {31'b0, stall[0]}, 32'h1);
        @(negedge clk);
        #1;
        chk("t5_busy1", {31'b0, stall[0]}, 32'h1);
        @(negedge clk);
        fl[0] = 1'b1;
        #1;
        chk("t5_flush_stall", {31'b0, stall[0]}, 32'h0);
        access(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 4, 32'hCAFEF00D, 1'b0, "t5_lw");
        idle(0, "t5_after");
        // T6: zero wait states, back-to-back, then reset mid-BUSY
        access(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h11111111, 2, 32'h0, 1'b0, "t6_sw");
        access(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 2, 32'h11111111, 1'b0, "t6_lw");
        access(1, 1'b0, 2'b00, 1'b0, 32'h41, 32'h00000022, 2, 32'h0, 1'b0, "t6_sb");
        access(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 2, 32'h11112211, 1'b0, "t6_lw2");
        idle(1, "t6_after");
        @(negedge clk);
        en[1] = 1'b1; rdq[1] = 1'b0; wid[1] = 2'b10; addr[1] = 32'h40; wd[1] = 32'h99999999;
        #1;
        chk("t6_accept", {31'b0, stall[1]}, 32'h1);
        @(negedge clk);
        #1;
        chk("t6_busy", {31'b0, stall[1]}, 32'h1);
        rst[1] = 1'b1;
        #1;
        chk("t6_rst_stall", {31'b0, stall[1]}, 32'h0);
        chk("t6_rst_data", dout[1], 32'h0);
        chk("t6_rst_err", {31'b0, err[1]}, 32'h0);
        @(negedge clk);
        rst[1] = 1'b0; en[1] = 1'b0;
        access(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 2, 32'h11112211, 1'b0, "t6_lw_norst");
        idle(1, "t6_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
